// File: rtl/arbiter_spec_monitor_n_if.sv
// rtl/arbiter_spec_monitor_n_if.sv - environment and controllable inputs watched by the arbiter spec monitor
interface arbiter_spec_monitor_n_if #(
    parameter int N_CLIENTS = 4,
    parameter int MASTER_W  = 2
);
    logic                 i_ready;
    logic [N_CLIENTS-1:0] i_req;
    logic [N_CLIENTS-1:0] controllable_grant;
    logic [MASTER_W-1:0]  controllable_master;

    modport master (output i_ready, i_req, controllable_grant, controllable_master);
    modport slave  (input  i_ready, i_req, controllable_grant, controllable_master);
endinterface

// File: rtl/arbiter_spec_monitor_n.sv
// rtl/arbiter_spec_monitor_n.sv - N-client arbiter error monitor: grant/master safety, mutex and bounded fairness
module arbiter_spec_monitor_n #(
    parameter int N_CLIENTS  = 4,
    parameter int MASTER_W   = 2,
    parameter int FAIR_BOUND = 4,
    parameter int CNT_W      = 4,
    parameter bit MUTEX_CHK  = 1'b1,
    parameter bit ENV_REARM  = 1'b1,
    parameter bit STICKY_ERR = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    arbiter_spec_monitor_n_if.slave bus,
    output logic                    o_err,
    output logic                    o_safety_err,
    output logic                    o_fair_err,
    output logic [CNT_W-1:0]        o_fair_cnt
);
    localparam logic [0:0]       ST_WAIT_ENV = 1'b0;
    localparam logic [0:0]       ST_COLLECT  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] BOUND       = CNT_W'(FAIR_BOUND);

    if ((2 ** MASTER_W) < N_CLIENTS) begin : g_bad_master_w
        $error("arbiter_spec_monitor_n: MASTER_W too narrow for N_CLIENTS");
    end
    if (FAIR_BOUND > ((2 ** CNT_W) - 1)) begin : g_bad_fair_bound
        $error("arbiter_spec_monitor_n: FAIR_BOUND exceeds fairness counter range");
    end

    logic                 r_ready;
    logic [N_CLIENTS-1:0] r_grant;
    logic [N_CLIENTS-1:0] r_sys_done;
    logic [0:0]           r_state;
    logic [CNT_W-1:0]     r_fair_cnt;

    logic [N_CLIENTS-1:0] w_master_hit;
    logic [N_CLIENTS-1:0] w_sys_fair;
    logic                 w_mismatch;
    logic                 w_mutex;
    logic                 w_safety;
    logic                 w_fair;
    logic                 w_done_all;

    // Master indices beyond the client range deliberately decode to no client.
    always_comb begin
        w_master_hit = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_master_hit[i] = (bus.controllable_master == MASTER_W'(i));
        end
    end

    assign w_sys_fair = w_master_hit | ~bus.i_req;
    assign w_mismatch = r_ready & (|(r_grant ^ w_master_hit));
    assign w_mutex    = MUTEX_CHK & ($countones(bus.controllable_grant) > 1);
    // Mutex is purely combinational on the inputs, so gate with reset to keep flags quiet while held.
    assign w_safety   = i_rst_n & (w_mismatch | w_mutex);
    assign w_fair     = (r_fair_cnt >= BOUND);
    assign w_done_all = &r_sys_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready    <= 1'b0;
            r_grant    <= '0;
            r_sys_done <= '0;
            r_state    <= ST_WAIT_ENV;
            r_fair_cnt <= '0;
        end else begin
            r_ready <= bus.i_ready;
            r_grant <= bus.controllable_grant;
            case (r_state)
                ST_WAIT_ENV: begin
                    if (bus.i_ready) begin
                        r_state <= ST_COLLECT;
                    end
                end
                default: begin
                    if (w_done_all) begin
                        r_sys_done <= '0;
                        r_fair_cnt <= '0;
                        if (ENV_REARM) begin
                            r_state <= ST_WAIT_ENV;
                        end
                    end else begin
                        r_sys_done <= r_sys_done | w_sys_fair;
                        if (r_fair_cnt != CNT_MAX) begin
                            r_fair_cnt <= r_fair_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    if (STICKY_ERR) begin : g_sticky
        logic r_err_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_err_q <= 1'b0;
            end else begin
                r_err_q <= r_err_q | w_safety | w_fair;
            end
        end

        assign o_err = i_rst_n & (r_err_q | w_safety | w_fair);
    end else begin : g_comb
        assign o_err = i_rst_n & (w_safety | w_fair);
    end

    assign o_safety_err = w_safety;
    assign o_fair_err   = w_fair;
    assign o_fair_cnt   = r_fair_cnt;
endmodule

// File: tb/tb_arbiter_spec_monitor_n.sv
// tb/tb_arbiter_spec_monitor_n.sv - directed and random checks of arbiter_spec_monitor_n against a window-level model
module tb_arbiter_spec_monitor_n;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    arbiter_spec_monitor_n_if #(.N_CLIENTS(4), .MASTER_W(2)) if_a ();
    arbiter_spec_monitor_n_if #(.N_CLIENTS(3), .MASTER_W(2)) if_c ();

    logic       a_err, a_safe, a_fair;
    logic [3:0] a_cnt;
    logic       b_err, b_safe, b_fair;
    logic [3:0] b_cnt;
    logic       c_err, c_safe, c_fair;
    logic [3:0] c_cnt;

    arbiter_spec_monitor_n #(
        .N_CLIENTS(4), .MASTER_W(2), .FAIR_BOUND(4), .CNT_W(4),
        .MUTEX_CHK(1'b1), .ENV_REARM(1'b1), .STICKY_ERR(1'b0)
    ) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_a),
        .o_err(a_err), .o_safety_err(a_safe), .o_fair_err(a_fair), .o_fair_cnt(a_cnt)
    );

    arbiter_spec_monitor_n #(
        .N_CLIENTS(4), .MASTER_W(2), .FAIR_BOUND(15), .CNT_W(4),
        .MUTEX_CHK(1'b0), .ENV_REARM(1'b0), .STICKY_ERR(1'b1)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_a),
        .o_err(b_err), .o_safety_err(b_safe), .o_fair_err(b_fair), .o_fair_cnt(b_cnt)
    );

    arbiter_spec_monitor_n #(
        .N_CLIENTS(3), .MASTER_W(2), .FAIR_BOUND(4), .CNT_W(4),
        .MUTEX_CHK(1'b1), .ENV_REARM(1'b1), .STICKY_ERR(1'b0)
    ) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_c),
        .o_err(c_err), .o_safety_err(c_safe), .o_fair_err(c_fair), .o_fair_cnt(c_cnt)
    );

    // Model: a fairness "window" is armed by env readiness, accumulates the set of clients
    // already served (or not asking), and is judged one cycle after the set becomes complete.
    typedef struct {
        int n;
        bit mutex;
        int fb;
        bit rearm;
        bit sticky;
        int cmax;
    } cfg_t;

    typedef struct {
        bit rdy_q;
        int gq;
        bit armed;
        int cov;
        int cnt;
        bit err_q;
    } m_t;

    cfg_t cfg [3];
    m_t   mdl [3];

    function automatic int hit(input int n, input int ms);
        return (ms < n) ? (1 << ms) : 0;
    endfunction

    task automatic get_in(input int k, output int rdy, output int req, output int gnt, output int ms);
        if (k < 2) begin
            rdy = int'(if_a.i_ready);
            req = int'(if_a.i_req);
            gnt = int'(if_a.controllable_grant);
            ms  = int'(if_a.controllable_master);
        end else begin
            rdy = int'(if_c.i_ready);
            req = int'(if_c.i_req);
            gnt = int'(if_c.controllable_grant);
            ms  = int'(if_c.controllable_master);
        end
    endtask

    task automatic expect_outs(input int k, output bit s, output bit f, output bit e);
        int rdy, req, gnt, ms;
        get_in(k, rdy, req, gnt, ms);
        s = (mdl[k].rdy_q && (mdl[k].gq != hit(cfg[k].n, ms))) ||
            (cfg[k].mutex && ($countones(gnt) > 1));
        f = (mdl[k].cnt >= cfg[k].fb);
        e = s || f || (cfg[k].sticky && mdl[k].err_q);
    endtask

    task automatic step_model(input int k);
        int rdy, req, gnt, ms, full;
        bit s, f, e;
        m_t m;
        get_in(k, rdy, req, gnt, ms);
        expect_outs(k, s, f, e);
        full = (1 << cfg[k].n) - 1;
        m = mdl[k];
        m.err_q = m.err_q || s || f;
        if (!m.armed) begin
            m.armed = (rdy != 0);
        end else if (m.cov == full) begin
            m.cov   = 0;
            m.cnt   = 0;
            m.armed = !cfg[k].rearm;
        end else begin
            m.cov = (m.cov | hit(cfg[k].n, ms) | ~req) & full;
            m.cnt = (m.cnt < cfg[k].cmax) ? m.cnt + 1 : m.cnt;
        end
        m.rdy_q = (rdy != 0);
        m.gq    = gnt;
        mdl[k]  = m;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mdl[k] = '{rdy_q: 1'b0, gq: 0, armed: 1'b0, cov: 0, cnt: 0, err_q: 1'b0};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int k, output logic [31:0] e, output logic [31:0] s,
                           output logic [31:0] f, output logic [31:0] c);
        case (k)
            0:       begin e = 32'(a_err); s = 32'(a_safe); f = 32'(a_fair); c = 32'(a_cnt); end
            1:       begin e = 32'(b_err); s = 32'(b_safe); f = 32'(b_fair); c = 32'(b_cnt); end
            default: begin e = 32'(c_err); s = 32'(c_safe); f = 32'(c_fair); c = 32'(c_cnt); end
        endcase
    endtask

    task automatic tick_check(input string tag);
        logic [31:0] oe, os, of, oc;
        bit s, f, e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            expect_outs(k, s, f, e);
            get_obs(k, oe, os, of, oc);
            chk($sformatf("%s/dut%0d/err", tag, k), oe, 32'(e));
            chk($sformatf("%s/dut%0d/safety", tag, k), os, 32'(s));
            chk($sformatf("%s/dut%0d/fair", tag, k), of, 32'(f));
            chk($sformatf("%s/dut%0d/cnt", tag, k), oc, 32'(mdl[k].cnt));
        end
    endtask

    task automatic adv();
        for (int k = 0; k < 3; k++) step_model(k);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic rdy, input logic [3:0] req, input logic [3:0] gnt, input logic [1:0] ms);
        if_a.i_ready             = rdy;
        if_a.i_req               = req;
        if_a.controllable_grant  = gnt;
        if_a.controllable_master = ms;
    endtask

    task automatic set_c(input logic rdy, input logic [2:0] req, input logic [2:0] gnt, input logic [1:0] ms);
        if_c.i_ready             = rdy;
        if_c.i_req               = req;
        if_c.controllable_grant  = gnt;
        if_c.controllable_master = ms;
    endtask

    // Asynchronous reset pulse landing mid-cycle, away from any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, "/a_err"}, 32'(a_err), 0);
        chk({tag, "/a_safe"}, 32'(a_safe), 0);
        chk({tag, "/b_err"}, 32'(b_err), 0);
        chk({tag, "/b_cnt"}, 32'(b_cnt), 0);
        chk({tag, "/c_err"}, 32'(c_err), 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        int nxt_a, nxt_c;
        logic [3:0] ga;
        logic [2:0] gc;

        cfg[0] = '{n: 4, mutex: 1'b1, fb: 4,  rearm: 1'b1, sticky: 1'b0, cmax: 15};
        cfg[1] = '{n: 4, mutex: 1'b0, fb: 15, rearm: 1'b0, sticky: 1'b1, cmax: 15};
        cfg[2] = '{n: 3, mutex: 1'b1, fb: 4,  rearm: 1'b1, sticky: 1'b0, cmax: 15};
        model_reset();

        // Reset held with a mutex-violating grant: every flag must stay low.
        rst_n = 1'b0;
        set_a(1'b1, 4'hF, 4'b0110, 2'd0);
        set_c(1'b1, 3'b000, 3'b011, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/a_err", 32'(a_err), 0);
        chk("reset/a_safe", 32'(a_safe), 0);
        chk("reset/a_fair", 32'(a_fair), 0);
        chk("reset/a_cnt", 32'(a_cnt), 0);
        chk("reset/b_err", 32'(b_err), 0);
        chk("reset/c_safe", 32'(c_safe), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_c(1'b0, 3'b000, 3'b000, 2'd0);

        // T1: rotating master with grant matching next-cycle master.
        for (int t = 0; t < 12; t++) begin
            set_a(1'b1, 4'hF, 4'(1 << ((t + 1) % 4)), 2'(t % 4));
            tick_check("t1");
            chk("t1/a_safe", 32'(a_safe), 0);
            adv();
        end

        // T2: registered grant 0001 while master points at client 1.
        do_reset("t2rst");
        set_a(1'b1, 4'h0, 4'b0001, 2'd0);
        tick_check("t2a");
        adv();
        set_a(1'b0, 4'h0, 4'b0000, 2'd1);
        tick_check("t2b");
        chk("t2/a_safe", 32'(a_safe), 1);
        chk("t2/a_err", 32'(a_err), 1);
        chk("t2/a_fair", 32'(a_fair), 0);
        adv();

        // T3: two grant bits at once; only the mutex-checking instance complains.
        set_a(1'b0, 4'h0, 4'b0110, 2'd1);
        tick_check("t3");
        chk("t3/a_safe", 32'(a_safe), 1);
        chk("t3/b_safe", 32'(b_safe), 0);
        adv();

        // T4: master stuck at 0 with all clients requesting; window never completes.
        do_reset("t4rst");
        for (int j = 0; j < 20; j++) begin
            set_a((j == 0), 4'hF, 4'b0001, 2'd0);
            tick_check("t4");
            exp_cnt = (j == 0) ? 0 : ((j - 1 > 15) ? 15 : j - 1);
            chk($sformatf("t4/a_cnt/%0d", j), 32'(a_cnt), 32'(exp_cnt));
            chk($sformatf("t4/a_fair/%0d", j), 32'(a_fair), 32'(exp_cnt >= 4));
            chk($sformatf("t4/b_fair/%0d", j), 32'(b_fair), 32'(exp_cnt >= 15));
            adv();
        end

        // T5: single-cycle safety violation latches the sticky instance until reset.
        do_reset("t5rst");
        set_a(1'b1, 4'h0, 4'b0001, 2'd0);
        tick_check("t5a");
        adv();
        set_a(1'b0, 4'h0, 4'b0000, 2'd1);
        tick_check("t5b");
        chk("t5/b_safe_hit", 32'(b_safe), 1);
        adv();
        for (int j = 0; j < 5; j++) begin
            set_a(1'b0, 4'h0, 4'b0000, 2'd0);
            tick_check("t5c");
            chk($sformatf("t5/b_err_held/%0d", j), 32'(b_err), 1);
            chk($sformatf("t5/b_safe/%0d", j), 32'(b_safe), 0);
            chk($sformatf("t5/a_err/%0d", j), 32'(a_err), 0);
            adv();
        end
        do_reset("t5clr");
        tick_check("t5d");
        chk("t5/b_err_cleared", 32'(b_err), 0);
        adv();

        // T6: three clients, master index 3 hits nobody, no requests.
        do_reset("t6rst");
        set_a(1'b0, 4'h0, 4'b0000, 2'd0);
        for (int j = 0; j < 4; j++) begin
            set_c((j == 0), 3'b000, 3'b000, 2'd3);
            tick_check("t6");
            exp_cnt = (j == 2) ? 1 : 0;
            chk($sformatf("t6/c_cnt/%0d", j), 32'(c_cnt), 32'(exp_cnt));
            chk($sformatf("t6/c_err/%0d", j), 32'(c_err), 0);
            adv();
        end

        // Random phase: grants usually predict the next master, sometimes not.
        do_reset("rndrst");
        nxt_a = 0;
        nxt_c = 0;
        for (int t = 0; t < 300; t++) begin
            int ms_a, ms_c;
            ms_a  = nxt_a;
            ms_c  = nxt_c;
            nxt_a = int'($urandom_range(0, 3));
            nxt_c = int'($urandom_range(0, 3));
            ga = ($urandom_range(0, 3) != 0) ? 4'(1 << nxt_a) : 4'($urandom_range(0, 15));
            gc = ($urandom_range(0, 3) != 0) ? 3'(hit(3, nxt_c)) : 3'($urandom_range(0, 7));
            set_a(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ga, 2'(ms_a));
            set_c(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), gc, 2'(ms_c));
            tick_check("rnd");
            adv();
            if (t == 150) do_reset("rndmid");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
